// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - shared opcode constants and opcode type for the ALU
//
// Purpose : defines the 2-bit ALU operation type and its four opcode values.
// Ports   : none (package).

package alu_unit_pkg;

   typedef enum logic [1:0] {
      ALU_And = 2'b00,
      ALU_Add = 2'b01,
      ALU_Sub = 2'b10,
      ALU_Or  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/alu_unit_comb.sv
// rtl/alu_unit_comb.sv - combinational ALU datapath: result and flags
//
// Purpose : computes AND/ADD/SUB/OR of two WIDTH-bit operands plus the
//           zero, negative, carry/borrow and signed-overflow flags.
// Ports   : a_i, b_i   - operands (a_i is the minuend for SUB)
//           op_i       - operation select
//           result_o   - low WIDTH bits of the result
//           zero_o     - result equals 0
//           negative_o - result MSB
//           carry_o    - carry out (ADD) or borrow (SUB), else 0
//           overflow_o - signed overflow (ADD/SUB), else 0

import alu_unit_pkg::*;

module alu_comb #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  alu_op_e          op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             negative_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] diff_ext;

   // One extra bit on each side: for the sum it is the carry out, for the
   // difference it becomes 1 exactly when a_i < b_i (the borrow).
   assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
   assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      result_o   = '0;
      carry_o    = 1'b0;
      overflow_o = 1'b0;
      case (op_i)
         ALU_And: result_o = a_i & b_i;
         ALU_Add: begin
            result_o   = sum_ext[WIDTH-1:0];
            carry_o    = sum_ext[WIDTH];
            // Same-sign operands whose sum flips sign.
            overflow_o = (a_i[MSB] == b_i[MSB]) && (sum_ext[MSB] != a_i[MSB]);
         end
         ALU_Sub: begin
            result_o   = diff_ext[WIDTH-1:0];
            carry_o    = diff_ext[WIDTH];
            // Opposite-sign operands whose difference leaves the minuend's sign.
            overflow_o = (a_i[MSB] != b_i[MSB]) && (diff_ext[MSB] != a_i[MSB]);
         end
         ALU_Or:  result_o = a_i | b_i;
         default: result_o = '0;
      endcase
   end

   assign zero_o     = (result_o == '0);
   assign negative_o = result_o[MSB];

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - one-cycle registered ALU wrapping the alu_comb datapath
//
// Purpose : registers the alu_comb result and flags on each valid input;
//           holds them otherwise. No backpressure, one result per cycle.
// Ports   : clk, reset          - clock, asynchronous active-high reset
//           IN1, IN2, AluOp     - operands and operation select
//           in_valid            - operands/AluOp valid this cycle
//           Output, out_valid   - registered result and its valid strobe
//           zero, negative,
//           carry, overflow     - registered flags for Output

import alu_unit_pkg::*;

module alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic [1:0]       AluOp,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Output,
   output logic             out_valid,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] comb_result;
   logic             comb_zero;
   logic             comb_negative;
   logic             comb_carry;
   logic             comb_overflow;

   logic [WIDTH-1:0] result_q,   result_d;
   logic             zero_q,     zero_d;
   logic             negative_q, negative_d;
   logic             carry_q,    carry_d;
   logic             overflow_q, overflow_d;
   logic             valid_q,    valid_d;

   alu_comb #(
      .WIDTH (WIDTH)
   ) u_alu_comb (
      .a_i        (IN1),
      .b_i        (IN2),
      .op_i       (alu_op_e'(AluOp)),
      .result_o   (comb_result),
      .zero_o     (comb_zero),
      .negative_o (comb_negative),
      .carry_o    (comb_carry),
      .overflow_o (comb_overflow)
   );

   // Result and flags load only on a valid cycle; the valid strobe simply
   // follows in_valid one cycle later.
   always_comb begin
      result_d   = result_q;
      zero_d     = zero_q;
      negative_d = negative_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      valid_d    = in_valid;
      if (in_valid) begin
         result_d   = comb_result;
         zero_d     = comb_zero;
         negative_d = comb_negative;
         carry_d    = comb_carry;
         overflow_d = comb_overflow;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q   <= '0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         result_q   <= result_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end

   assign Output    = result_q;
   assign zero      = zero_q;
   assign negative  = negative_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit

module tb_alu_unit;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk;
   logic        reset;
   logic [31:0] IN1;
   logic [31:0] IN2;
   logic [1:0]  AluOp;
   logic        in_valid;
   logic [31:0] Output;
   logic        out_valid;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_out;
   logic        m_valid, m_z, m_n, m_c, m_v;

   alu_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .IN1       (IN1),
      .IN2       (IN2),
      .AluOp     (AluOp),
      .in_valid  (in_valid),
      .Output    (Output),
      .out_valid (out_valid),
      .zero      (zero),
      .negative  (negative),
      .carry     (carry),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, {31'd0, act}, {31'd0, exp});
   endtask

   // Reference arithmetic in plain integer terms: unsigned range for carry,
   // signed range for overflow.
   function automatic void model_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op, output logic [31:0] r,
                                    output logic c, output logic v);
      longint unsigned ua, ub, us;
      longint sa, sb, ss;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         2'b00: r = a & b;
         2'b01: begin
            us = ua + ub;
            r  = us[31:0];
            c  = (us > 64'h0000_0000_FFFF_FFFF);
            ss = sa + sb;
            v  = (ss > SMAX) || (ss < SMIN);
         end
         2'b10: begin
            us = ua - ub;
            r  = us[31:0];
            c  = (a < b);
            ss = sa - sb;
            v  = (ss > SMAX) || (ss < SMIN);
         end
         default: r = a | b;
      endcase
   endfunction

   // Expected register contents after each edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid = 1'b0; m_out = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
      end else begin
         m_valid = in_valid;
         if (in_valid) begin
            model_op(IN1, IN2, AluOp, m_out, m_c, m_v);
            m_z = (m_out == 32'd0);
            m_n = m_out[31];
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk ("mdl_out",   Output,    m_out);
      chk1("mdl_valid", out_valid, m_valid);
      chk1("mdl_zero",  zero,      m_z);
      chk1("mdl_neg",   negative,  m_n);
      chk1("mdl_carry", carry,     m_c);
      chk1("mdl_ovf",   overflow,  m_v);
   end

   task automatic dop(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [31:0] eo, input logic ez,
                      input logic en, input logic ec, input logic ev);
      @(negedge clk);
      IN1 = a; IN2 = b; AluOp = op; in_valid = 1'b1;
      @(posedge clk);
      #2;
      chk ({nm, "_out"},   Output,    eo);
      chk1({nm, "_valid"}, out_valid, 1'b1);
      chk1({nm, "_zero"},  zero,      ez);
      chk1({nm, "_neg"},   negative,  en);
      chk1({nm, "_carry"}, carry,     ec);
      chk1({nm, "_ovf"},   overflow,  ev);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; IN1 = '0; IN2 = '0; AluOp = 2'b00;
      #1;
      chk ("rst_out",   Output,    32'd0);
      chk1("rst_valid", out_valid, 1'b0);
      chk1("rst_flags", zero | negative | carry | overflow, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      dop("add_10_15",  32'd10,        32'd15,        2'b01, 32'd25,        0, 0, 0, 0);
      dop("sub_20_10",  32'd20,        32'd10,        2'b10, 32'd10,        0, 0, 0, 0);
      dop("sub_10_20",  32'd10,        32'd20,        2'b10, 32'hFFFF_FFF6, 0, 1, 1, 0);
      dop("and_a_3",    32'hA,         32'h3,         2'b00, 32'h2,         0, 0, 0, 0);
      dop("or_a_3",     32'hA,         32'h3,         2'b11, 32'hB,         0, 0, 0, 0);
      dop("add_wrap",   32'hFFFF_FFFF, 32'd1,         2'b01, 32'd0,         1, 0, 1, 0);
      dop("sub_eq",     32'd5,         32'd5,         2'b10, 32'd0,         1, 0, 0, 0);
      dop("sub_ovf",    32'h8000_0000, 32'd1,         2'b10, 32'h7FFF_FFFF, 0, 0, 0, 1);
      dop("and_zero",   32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00, 32'd0,         1, 0, 0, 0);
      dop("add_ovf",    32'h7FFF_FFFF, 32'd1,         2'b01, 32'h8000_0000, 0, 1, 0, 1);

      // Hold: idle cycles keep the last result.
      @(negedge clk);
      in_valid = 1'b0; IN1 = 32'h1234_5678; IN2 = 32'h1; AluOp = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         chk1("hold_valid", out_valid, 1'b0);
         chk ("hold_out",   Output,    32'h8000_0000);
         chk1("hold_ovf",   overflow,  1'b1);
      end

      // Mixed traffic, checked against the model every cycle.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         IN1      = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
         IN2      = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
         AluOp    = 2'($urandom_range(0, 3));
         in_valid = ($urandom_range(0, 3) != 0);
      end

      // Reset mid-stream, asserted between edges with a valid input pending.
      dop("pre_rst", 32'd100, 32'd1, 2'b01, 32'd101, 0, 0, 0, 0);
      @(negedge clk);
      IN1 = 32'd3; IN2 = 32'd4; AluOp = 2'b01; in_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk ("midrst_out",   Output,    32'd0);
      chk1("midrst_valid", out_valid, 1'b0);
      chk1("midrst_flags", zero | negative | carry | overflow, 1'b0);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #2;
      chk1("postrst_valid", out_valid, 1'b0);
      chk ("postrst_out",   Output,    32'd0);
      dop("first_after_rst", 32'd3, 32'd4, 2'b01, 32'd7, 0, 0, 0, 0);

      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port clk  input  1  the block's single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port IN1  input  WIDTH  first operand; the minuend for SUB.
REQ-005 Port IN2  input  WIDTH  second operand; the subtrahend for SUB.
REQ-006 Port AluOp  input  2  operation select.
REQ-007 Port in_valid  input  1  operands and AluOp are valid this cycle.
REQ-008 Port Output  output  WIDTH  registered result.
REQ-009 Port out_valid  output  1  Output and flags hold a new result this cycle.
REQ-010 Port zero  output  1  registered flag: result equals 0.
REQ-011 Port negative  output  1  registered flag: result MSB.
REQ-012 Port carry  output  1  registered flag: carry out for ADD, borrow for SUB, 0 otherwise.
REQ-013 Port overflow  output  1  registered flag: signed overflow for ADD/SUB, 0 otherwise.

Function
REQ-014 AluOp encoding SHALL be 2'b00 ALU_And (IN1 & IN2), 2'b01 ALU_Add (IN1 + IN2), 2'b10 ALU_Sub (IN1 - IN2), 2'b11 ALU_Or (IN1 | IN2).
REQ-015 Arithmetic SHALL be modulo 2^WIDTH; Output SHALL hold the low WIDTH bits of the result.
REQ-016 ADD carry SHALL be bit WIDTH of the (WIDTH+1)-bit unsigned sum.
REQ-017 SUB carry SHALL be 1 exactly when IN1 < IN2, unsigned (borrow).
REQ-018 ADD overflow SHALL be 1 when both operands have the same sign and the result sign differs from it.
REQ-019 SUB overflow SHALL be 1 when the operand signs differ and the result sign differs from IN1's sign.
REQ-020 For AND and OR, carry and overflow SHALL be 0.
REQ-021 Latency SHALL be exactly one cycle: a cycle with in_valid=1 SHALL produce Output, the flags and out_valid=1 after the next rising edge.
REQ-022 When in_valid=0, out_valid SHALL be 0 on the next edge, and Output and the flags SHALL hold their previous values.
REQ-023 Back-to-back in_valid cycles SHALL produce one result per cycle with no stall; the block has no backpressure.
REQ-024 zero and negative SHALL be derived from the same WIDTH-bit result that is registered into Output.

Reset
REQ-025 Asserting reset SHALL immediately clear Output, zero, negative, carry, overflow and out_valid to 0, independent of clk.
REQ-026 Inputs applied while reset is asserted SHALL be discarded.
REQ-027 The first result SHALL be captured on the first rising edge after reset deasserts at which in_valid=1.
REQ-028 A reset asserted during operation SHALL discard any pending result; no stale out_valid SHALL appear after reset releases.

Structure
REQ-029 The opcode constants ALU_And, ALU_Add, ALU_Sub and ALU_Or, and the 2-bit opcode type, SHALL be defined in the shared constants package used by the processor.
REQ-030 The combinational datapath (result and flag computation) SHALL be one sub-module, alu_comb, wrapped by the registering stage in alu_unit.

Verification
REQ-031 A bench SHALL cover each of the following directed scenarios:
- ADD: IN1=10, IN2=15, in_valid=1 -> next cycle Output=25, out_valid=1, zero=0, carry=0, overflow=0.
- SUB: IN1=20, IN2=10 -> Output=10; then IN1=10, IN2=20 -> Output=32'hFFFFFFF6, negative=1, carry=1.
- AND and OR: IN1=32'hA, IN2=32'h3 -> AND gives Output=32'h2; OR gives Output=32'hB.
- Overflow/zero: ADD 32'h7FFFFFFF + 1 -> Output=32'h80000000, overflow=1, negative=1; ADD 32'hFFFFFFFF + 1 -> Output=0, zero=1, carry=1.
- Hold: in_valid=0 for 3 cycles after a result -> out_valid=0, Output unchanged.
- Reset mid-stream: assert reset between clock edges while in_valid=1 -> all outputs 0 immediately; no out_valid on the first edge after release unless in_valid=1.
